ice40_ram_fifo_ctrl: RTL and testbench

- Synchronous single-clock FIFO controller that drives the read and write ports of one SB_RAM40_4K primitive in 256x16 mode (READ_MODE=0, WRITE_MODE=0).
- Sits directly upstream of the RAM instance: it generates WADDR/WE/WDATA and RADDR/RE, then consumes RDATA.
- Hides the RAM's 1-cycle read latency behind a 2-entry output buffer, so the output can stream one word per cycle.
- The parent ties the RAM's WCLK and RCLK to CLK.

---
 rtl/ice40_ram_fifo_ctrl.sv | 118 +++++++++++
 tb/tb_ice40_ram_fifo_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ice40_ram_fifo_ctrl.sv
// ice40_ram_fifo_ctrl
//   Single-clock FIFO controller for one SB_RAM40_4K in 256x16 mode
//   (READ_MODE=0, WRITE_MODE=0). It drives the RAM write/read ports and
//   hides the 1-cycle read latency behind a 2-entry output buffer
//   (head + skid), so one word per cycle can stream out.
//
// Ports
//   CLK, ASYNCRESETN        : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready     : write side (ready/valid)
//   out_data/out_valid/out_ready  : read side (ready/valid)
//   count                   : words held (RAM + in-flight read + buffer)
//   ram_WADDR/WDATA/WE/WCLKE/MASK : to RAM write port
//   ram_RADDR/RE/RCLKE      : to RAM read port
//   ram_RDATA               : from RAM, valid the cycle after ram_RE=1
module ice40_ram_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESETN,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic [10:0]           ram_WADDR,
  output logic [DATA_WIDTH-1:0] ram_WDATA,
  output logic                  ram_WE,
  output logic                  ram_WCLKE,
  output logic [15:0]           ram_MASK,
  output logic [10:0]           ram_RADDR,
  output logic                  ram_RE,
  output logic                  ram_RCLKE,
  input  logic [DATA_WIDTH-1:0] ram_RDATA
);

  localparam logic [ADDR_WIDTH:0] DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Pointers carry a wrap bit so full/empty of the RAM region is unambiguous.
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_pend;   // a RAM read was issued last cycle
  logic [1:0]            r_occ;    // output buffer occupancy, 0..2
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;

  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH:0]   w_ram_lvl;
  logic [2:0]            w_occ_next;
  logic                  w_re;

  // in_ready depends only on registered count and reset, never on out_ready.
  assign in_ready  = ASYNCRESETN & (r_count < DEPTH);
  assign w_push    = in_valid & in_ready;
  assign out_valid = (r_occ != 2'd0);
  assign w_pop     = out_valid & out_ready;
  assign out_data  = r_head;
  assign count     = r_count;

  // Only writes committed in earlier cycles are visible to the read side,
  // so a same-address read/write in one cycle cannot happen.
  assign w_ram_lvl = r_wptr - r_rptr;

  // Buffer slots already spoken for after this cycle; a read is issued only
  // when the result is guaranteed a slot, keeping occ + pend <= 2.
  assign w_occ_next = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};
  assign w_re       = (w_ram_lvl != '0) & (w_occ_next < 3'd2);

  assign ram_WE    = w_push;
  assign ram_WADDR = 11'(r_wptr[ADDR_WIDTH-1:0]);
  assign ram_WDATA = in_data;
  assign ram_WCLKE = 1'b1;
  assign ram_MASK  = '0;
  assign ram_RE    = w_re;
  assign ram_RADDR = 11'(r_rptr[ADDR_WIDTH-1:0]);
  assign ram_RCLKE = 1'b1;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_pend  <= 1'b0;
      r_occ   <= 2'd0;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_re)   r_rptr <= r_rptr + PTR_ONE;
      r_pend <= w_re;
      r_occ  <= w_occ_next[1:0];

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + PTR_ONE;
        2'b01:   r_count <= r_count - PTR_ONE;
        default: r_count <= r_count;
      endcase

      // A pop from a full buffer promotes the skid word to head.
      if (w_pop && (r_occ == 2'd2)) r_head <= r_skid;

      // Returning RAM data lands in head if head is free (or being freed
      // this cycle with nothing behind it), otherwise in the skid slot.
      // occ is at most 1 whenever pend is set, so this never collides
      // with the skid promotion above.
      if (r_pend) begin
        if ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop)) r_head <= ram_RDATA;
        else                                                r_skid <= ram_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_ice40_ram_fifo_ctrl.sv
module tb_ice40_ram_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  localparam int S_WE     = 0;
  localparam int S_WADDR  = 1;
  localparam int S_RE     = 2;
  localparam int S_RADDR  = 3;
  localparam int S_OVALID = 4;
  localparam int S_ODATA  = 5;
  localparam int S_INRDY  = 6;
  localparam int S_COUNT  = 7;
  localparam int S_TMO    = 8;

  logic        CLK = 1'b0;
  logic        ASYNCRESETN;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [AW:0] count;
  logic [10:0] ram_WADDR;
  logic [15:0] ram_WDATA;
  logic        ram_WE;
  logic        ram_WCLKE;
  logic [15:0] ram_MASK;
  logic [10:0] ram_RADDR;
  logic        ram_RE;
  logic        ram_RCLKE;
  logic [15:0] ram_RDATA = '0;

  always #5 CLK = ~CLK;

  ice40_ram_fifo_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count),
    .ram_WADDR(ram_WADDR), .ram_WDATA(ram_WDATA), .ram_WE(ram_WE),
    .ram_WCLKE(ram_WCLKE), .ram_MASK(ram_MASK),
    .ram_RADDR(ram_RADDR), .ram_RE(ram_RE), .ram_RCLKE(ram_RCLKE),
    .ram_RDATA(ram_RDATA)
  );

  // SB_RAM40_4K 256x16 behaviour: synchronous write, registered read.
  logic [15:0] mem [256];
  always @(posedge CLK) begin
    if (ram_WE) mem[ram_WADDR[7:0]] <= ram_WDATA;
    if (ram_RE) ram_RDATA <= mem[ram_RADDR[7:0]];
  end

  // Reference model: queue of words with the cycle each was accepted.
  // A word is presented three cycles after acceptance, never ahead of older words.
  logic [15:0] mq[$];
  int          mts[$];
  int          cyc = 0;
  int          wr_n = 0;
  int          rd_n = 0;
  int          pop_n = 0;
  int          total = 0;
  int          bad = 0;
  bit          finishing = 1'b0;

  typedef struct {
    int          at;
    int          sel;
    logic [31:0] val;
  } pin_t;
  pin_t pins[$];

  task automatic post(input int at, input int sel, input logic [31:0] val);
    pin_t p;
    p.at = at; p.sel = sel; p.val = val;
    pins.push_back(p);
  endtask

  function automatic logic [31:0] get_sig(input int sel);
    case (sel)
      S_WE:     return {31'b0, ram_WE};
      S_WADDR:  return {21'b0, ram_WADDR};
      S_RE:     return {31'b0, ram_RE};
      S_RADDR:  return {21'b0, ram_RADDR};
      S_OVALID: return {31'b0, out_valid};
      S_ODATA:  return {16'b0, out_data};
      S_INRDY:  return {31'b0, in_ready};
      S_COUNT:  return {27'b0, count};
      default:  return 32'd0;
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      S_WE:     return "pin_ram_WE";
      S_WADDR:  return "pin_ram_WADDR";
      S_RE:     return "pin_ram_RE";
      S_RADDR:  return "pin_ram_RADDR";
      S_OVALID: return "pin_out_valid";
      S_ODATA:  return "pin_out_data";
      S_INRDY:  return "pin_in_ready";
      S_COUNT:  return "pin_count";
      default:  return "wait_budget";
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic run_pins();
    for (int k = pins.size() - 1; k >= 0; k--) begin
      if (pins[k].at == cyc) begin
        chk(sel_name(pins[k].sel), get_sig(pins[k].sel), pins[k].val);
        pins.delete(k);
      end
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge CLK) begin
    bit exp_ready, exp_valid, push, pop;
    if (finishing) begin
      foreach (pins[k]) begin
        total++;
        bad++;
        $display("FAIL pin_unreached %s at=%0d got=none want=%0h",
                 sel_name(pins[k].sel), pins[k].at, pins[k].val);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (!ASYNCRESETN) begin
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_count",     {27'b0, count},     32'd0);
      chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
      chk("rst_ram_WE",    {31'b0, ram_WE},    32'd0);
      chk("rst_ram_RE",    {31'b0, ram_RE},    32'd0);
      chk("rst_ram_MASK",  {16'b0, ram_MASK},  32'd0);
      mq.delete();
      mts.delete();
      wr_n  = 0;
      rd_n  = 0;
      pop_n = 0;
      run_pins();
      cyc++;
    end else begin
      exp_ready = (mq.size() < DEPTH);
      exp_valid = (mq.size() > 0) && (mts[0] + 3 <= cyc);
      chk("count",     {27'b0, count},     mq.size());
      chk("in_ready",  {31'b0, in_ready},  {31'b0, exp_ready});
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      if (exp_valid) chk("out_data", {16'b0, out_data}, {16'b0, mq[0]});
      push = in_valid && exp_ready;
      pop  = exp_valid && out_ready;
      chk("ram_WE", {31'b0, ram_WE}, {31'b0, push});
      if (push) begin
        chk("ram_WADDR", {21'b0, ram_WADDR}, wr_n % DEPTH);
        chk("ram_WDATA", {16'b0, ram_WDATA}, {16'b0, in_data});
      end
      chk("static_ctrl", {ram_MASK, 14'b0, ram_WCLKE, ram_RCLKE}, 32'h0000_0003);
      if (ram_RE) begin
        chk("ram_RADDR", {21'b0, ram_RADDR}, rd_n % DEPTH);
        chk("read_after_write", {31'b0, rd_n < wr_n}, 32'd1);
        rd_n++;
      end
      if (pop) begin
        void'(mq.pop_front());
        void'(mts.pop_front());
        pop_n++;
      end
      if (push) begin
        mq.push_back(in_data);
        mts.push_back(cyc);
        wr_n++;
      end
      // Words read from RAM but not yet consumed live in the 2-entry buffer.
      chk("buffer_bound", {31'b0, (rd_n - pop_n) <= 2}, 32'd1);
      run_pins();
      cyc++;
    end
  end

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int start, g;
    ASYNCRESETN = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    repeat (3) @(posedge CLK);
    #1 ASYNCRESETN = 1'b1;
    post(cyc, S_INRDY, 1);
    repeat (2) nxt();

    // Single word through an empty FIFO.
    nxt();
    in_valid = 1'b1; in_data = 16'hA5A5; out_ready = 1'b1;
    post(cyc,     S_WE,     1);
    post(cyc,     S_WADDR,  0);
    post(cyc + 1, S_RE,     1);
    post(cyc + 1, S_RADDR,  0);
    post(cyc + 2, S_OVALID, 0);
    post(cyc + 3, S_OVALID, 1);
    post(cyc + 3, S_ODATA,  32'hA5A5);
    post(cyc + 4, S_COUNT,  0);
    nxt();
    in_valid = 1'b0;
    repeat (6) nxt();

    // Fill to full, refuse a 17th word, then drain in order.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      nxt();
    end
    in_valid = 1'b1; in_data = 16'h0BAD;
    post(cyc, S_COUNT, DEPTH);
    post(cyc, S_INRDY, 0);
    post(cyc, S_WE,    0);
    nxt();
    in_valid = 1'b0; out_ready = 1'b1;
    post(cyc,      S_ODATA, 0);
    post(cyc + 15, S_ODATA, 15);
    post(cyc + 16, S_COUNT, 0);
    repeat (20) nxt();

    // Streaming: one in, one out per cycle.
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h1000 + i); out_ready = 1'b1;
      nxt();
    end
    in_valid = 1'b0;
    repeat (6) nxt();

    // Random backpressure across many pointer wraps.
    start = wr_n;
    g = 0;
    while ((wr_n - start < 500) && (g < 20000)) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = 16'($urandom);
      out_ready = ($urandom % 3) != 0;
      nxt();
      g++;
    end
    if (g >= 20000) post(cyc, S_TMO, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    g = 0;
    while ((mq.size() != 0) && (g < 100)) begin
      nxt();
      g++;
    end
    if (g >= 100) post(cyc, S_TMO, 1);
    repeat (3) nxt();

    // Mid-operation reset: 10 words held, a pop triggers a RAM read, then
    // a reset pulse entirely between two clock edges.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h5000 + i);
      nxt();
    end
    in_valid = 1'b0;
    repeat (4) nxt();
    post(cyc, S_COUNT, 10);
    nxt();
    out_ready = 1'b1;
    #1 ASYNCRESETN = 1'b0;
    #5 ASYNCRESETN = 1'b1;
    nxt();
    in_valid = 1'b1; in_data = 16'h1234;
    post(cyc,     S_WADDR,  0);
    post(cyc + 3, S_OVALID, 1);
    post(cyc + 3, S_ODATA,  32'h1234);
    post(cyc + 4, S_OVALID, 0);
    nxt();
    in_valid = 1'b0;
    repeat (6) nxt();
    post(cyc, S_COUNT, 0);
    nxt();
    finishing = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
